// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the sixteen-bit serial deserializer.
package deser_pkg;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RECV    = 2'b01,
    ST_HOLD    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

endpackage

// File: rtl/sixteen_bit_deserializer_if.sv
// Serial input, word output and status bundle of the deserializer.
interface sixteen_bit_deserializer_if;

  logic        serial_in;
  logic        ss;
  logic        data_ack;
  logic [15:0] data_word;
  logic        data_valid;
  logic        frame_error;
  logic        overrun;
  logic        busy;
  logic [1:0]  state_q;

  modport master (
    output serial_in, ss, data_ack,
    input  data_word, data_valid, frame_error, overrun, busy, state_q
  );

  modport slave (
    input  serial_in, ss, data_ack,
    output data_word, data_valid, frame_error, overrun, busy, state_q
  );

endinterface

// File: rtl/deser_bit_counter.sv
// 4-bit frame bit counter with synchronous clear, enable and terminal-count flag.
module deser_bit_counter
  import deser_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + 1'b1;  // wraps to 0 after the last bit of a frame
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign tc_o = (count_q == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/sixteen_bit_deserializer.sv
// Framed LSB-first serial-to-16-bit deserializer with valid/ack word handoff.
// Optional sticky overrun flag enabled by DESER_OVERRUN_EN.
module sixteen_bit_deserializer
  import deser_pkg::*;
(
  input  logic                         clock,
  input  logic                         resetn,
  sixteen_bit_deserializer_if.slave    bus
);

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] data_word_q, data_word_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q;
  logic        busy_q;

  logic        cnt_clr, shift_en, complete, abort;
  logic        cnt_tc;

  deser_bit_counter u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (cnt_clr),
    .en_i   (shift_en),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = bus.ss ? ST_IDLE : ST_RECV;
      ST_RECV: begin
        if (bus.ss)
          state_d = ST_IDLE;
        else if (cnt_tc)
          state_d = ST_HOLD;
        else
          state_d = ST_RECV;
      end
      ST_HOLD: state_d = bus.ss ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: cnt_clr = 1'b1;
      ST_RECV: begin
        if (bus.ss) begin
          abort = 1'b1;
        end else begin
          shift_en = 1'b1;
          complete = cnt_tc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    shift_d      = shift_en ? {bus.serial_in, shift_q[15:1]} : shift_q;
    data_word_d  = complete ? shift_d : data_word_q;
    data_valid_d = data_valid_q;
    // A completion on the ack edge keeps valid high for the new word
    if (complete)
      data_valid_d = 1'b1;
    else if (bus.data_ack && data_valid_q)
      data_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q       <= '0;
      data_word_q   <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      data_word_q   <= data_word_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= abort;
      busy_q        <= (state_d == ST_RECV);
    end
  end

`ifdef DESER_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      overrun_q <= 1'b0;
    else if (complete && data_valid_q && !bus.data_ack)
      overrun_q <= 1'b1;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.data_word   = data_word_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;
  assign bus.state_q     = state_q;

endmodule

// File: tb/tb_sixteen_bit_deserializer.sv
// Directed self-checking bench for sixteen_bit_deserializer.
module tb_sixteen_bit_deserializer;

  logic clock;
  logic resetn;
  int   total;
  int   bad;

`ifdef DESER_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  sixteen_bit_deserializer_if bus ();

  sixteen_bit_deserializer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One rising edge; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Start edge with ss low, then n data bits; optional ack on the last bit's edge.
  task automatic send_bits(input logic [15:0] word, input int n, input logic ack_last);
    bus.ss = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      bus.serial_in = word[i];
      bus.data_ack  = ack_last && (i == n - 1);
      step();
    end
    bus.data_ack = 1'b0;
  endtask

  task automatic end_frame();
    bus.ss = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.ss        = 1'b1;
    bus.serial_in = 1'b0;
    bus.data_ack  = 1'b0;
    step();
    total++; if (bus.state_q !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", bus.state_q); end
    total++; if (bus.data_word !== 16'h0000) begin bad++; $display("FAIL reset_word got=%h exp=0000", bus.data_word); end
    total++; if ({bus.data_valid, bus.frame_error, bus.overrun, bus.busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.data_valid, bus.frame_error, bus.overrun, bus.busy});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_frame();
    bus.ss = 1'b0;
    step();
    total++; if (bus.state_q !== 2'b01 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL start_recv state=%b busy=%b exp=01/1", bus.state_q, bus.busy);
    end
    for (int i = 0; i < 15; i++) begin
      bus.serial_in = 16'hA5C3 >> i;
      step();
    end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL valid_before_16 got=%b exp=0", bus.data_valid); end
    bus.serial_in = 1'b1;  // bit 15 of A5C3
    step();
    total++; if (bus.data_word !== 16'hA5C3) begin bad++; $display("FAIL word_a5c3 got=%h exp=a5c3", bus.data_word); end
    total++; if (bus.data_valid !== 1'b1 || bus.busy !== 1'b0 || bus.state_q !== 2'b10) begin
      bad++; $display("FAIL complete_a5c3 valid=%b busy=%b state=%b exp=1/0/10", bus.data_valid, bus.busy, bus.state_q);
    end
    for (int i = 0; i < 3; i++) begin
      bus.serial_in = i[0];
      step();
    end
    total++; if (bus.data_word !== 16'hA5C3 || bus.state_q !== 2'b10) begin
      bad++; $display("FAIL hold_ignore word=%h state=%b exp=a5c3/10", bus.data_word, bus.state_q);
    end
    end_frame();
    total++; if (bus.state_q !== 2'b00) begin bad++; $display("FAIL hold_exit got=%b exp=00", bus.state_q); end
    bus.data_ack = 1'b1;
    step();
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b exp=0", bus.data_valid); end
    step();
    bus.data_ack = 1'b0;
    total++; if (bus.data_valid !== 1'b0 || bus.data_word !== 16'hA5C3) begin
      bad++; $display("FAIL ack_idle valid=%b word=%h exp=0/a5c3", bus.data_valid, bus.data_word);
    end
  endtask

  task automatic test_abort();
    send_bits(16'h1111, 7, 1'b0);
    bus.ss = 1'b1;
    step();
    total++; if (bus.frame_error !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", bus.frame_error); end
    total++; if (bus.state_q !== 2'b00 || bus.data_word !== 16'hA5C3 || bus.data_valid !== 1'b0) begin
      bad++; $display("FAIL abort_state state=%b word=%h valid=%b exp=00/a5c3/0", bus.state_q, bus.data_word, bus.data_valid);
    end
    step();
    total++; if (bus.frame_error !== 1'b0) begin bad++; $display("FAIL abort_one_cycle got=%b exp=0", bus.frame_error); end
  endtask

  task automatic test_ack_same_edge();
    send_bits(16'h1111, 16, 1'b0);
    end_frame();
    send_bits(16'h00FF, 16, 1'b1);
    total++; if (bus.data_word !== 16'h00FF || bus.data_valid !== 1'b1) begin
      bad++; $display("FAIL ack_same_edge word=%h valid=%b exp=00ff/1", bus.data_word, bus.data_valid);
    end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL no_overrun got=%b exp=0", bus.overrun); end
    end_frame();
    bus.data_ack = 1'b1;
    step();
    bus.data_ack = 1'b0;
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL next_ack got=%b exp=0", bus.data_valid); end
  endtask

  task automatic test_back_to_back();
    send_bits(16'h1234, 16, 1'b0);
    total++; if (bus.data_word !== 16'h1234) begin bad++; $display("FAIL word_1234 got=%h exp=1234", bus.data_word); end
    end_frame();
    send_bits(16'hFFFF, 16, 1'b0);
    total++; if (bus.data_word !== 16'hFFFF || bus.data_valid !== 1'b1) begin
      bad++; $display("FAIL word_ffff word=%h valid=%b exp=ffff/1", bus.data_word, bus.data_valid);
    end
    total++; if (bus.overrun !== OVR_EXP) begin bad++; $display("FAIL overrun got=%b exp=%b", bus.overrun, OVR_EXP); end
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    send_bits(16'hBEEF, 9, 1'b0);
    resetn = 1'b0;
    #1;
    total++; if (bus.state_q !== 2'b00 || bus.data_word !== 16'h0000) begin
      bad++; $display("FAIL async_reset state=%b word=%h exp=00/0000", bus.state_q, bus.data_word);
    end
    total++; if ({bus.data_valid, bus.frame_error, bus.overrun, bus.busy} !== 4'b0000) begin
      bad++; $display("FAIL async_reset_flags got=%b exp=0000", {bus.data_valid, bus.frame_error, bus.overrun, bus.busy});
    end
    step();
    total++; if (bus.frame_error !== 1'b0) begin bad++; $display("FAIL reset_no_ferr got=%b exp=0", bus.frame_error); end
    resetn = 1'b1;
    send_bits(16'h5A5A, 16, 1'b0);
    total++; if (bus.data_word !== 16'h5A5A || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL word_5a5a word=%h valid=%b ovr=%b exp=5a5a/1/0", bus.data_word, bus.data_valid, bus.overrun);
    end
    end_frame();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_frame();
    test_abort();
    test_ack_same_edge();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
